// File: rtl/console_rx_port.sv
// rtl/console_rx_port.sv - memory-mapped console input port with RX byte FIFO
// Polled by the core through STATUS/RXDATA; bytes arrive on a one-cycle strobe.
module console_rx_port #(
    parameter int ADDR_WIDTH = 22,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_rdata_o,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] REG_RXDATA = 2'b00;
    localparam logic [1:0] REG_STATUS = 2'b01;
    localparam logic [1:0] REG_CTRL   = 2'b10;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q;
    logic          irq_q;

    logic [1:0]    reg_idx;
    logic          is_rd, is_wr;
    logic          not_empty, full;
    logic          pop, push, flush, ovf_set, ovf_clr, ctrl_wr;
    logic [31:0]   count_ext;

    logic unused_bits;
    assign unused_bits = ^{data_addr_i[ADDR_WIDTH-1:4], data_addr_i[1:0],
                           data_be_i[3:1], data_wdata_i[31:2]};

    assign data_gnt_o    = data_req_i;
    assign data_rdata_o  = rdata_q;
    assign data_rvalid_o = rvalid_q;
    assign rx_irq_o      = irq_q;

    always_comb begin
        reg_idx   = data_addr_i[3:2];
        is_rd     = data_req_i & ~data_we_i;
        is_wr     = data_req_i & data_we_i;
        not_empty = (count_q != '0);
        full      = (count_q == DEPTH_C);
        count_ext = 32'(count_q);

        pop     = is_rd & (reg_idx == REG_RXDATA) & not_empty;
        ctrl_wr = is_wr & (reg_idx == REG_CTRL) & data_be_i[0];
        flush   = ctrl_wr & data_wdata_i[0];
        ovf_clr = ctrl_wr & data_wdata_i[1];

        // A pop frees the slot this cycle, so a push into a full FIFO still lands.
        push    = rx_valid_i & ~flush & (~full | pop);
        ovf_set = rx_valid_i & ~flush & full & ~pop;
    end

    // Read data reflects the state before this cycle's push/pop.
    always_comb begin
        rdata_d = rdata_q;
        if (data_req_i) begin
            rdata_d = 32'h0;
            if (is_rd) begin
                case (reg_idx)
                    REG_RXDATA: if (not_empty) rdata_d = {23'b0, 1'b1, mem[rd_ptr_q]};
                    REG_STATUS: rdata_d = {16'h0, count_ext[7:0], 5'b0, ovf_q, full, not_empty};
                    default:    rdata_d = 32'h0;
                endcase
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= data_req_i;
            irq_q    <= (count_d != '0);
        end
    end

    // Storage carries no reset; only slots below count are ever read.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= rx_data_i;
    end

endmodule

// File: tb/tb_console_rx_port.sv
// tb/tb_console_rx_port.sv - self-checking bench for console_rx_port
module tb_console_rx_port;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        data_req_i = 1'b0;
    logic [21:0] data_addr_i = '0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic [31:0] data_rdata_o;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h0;
    logic        rx_irq_o;

    int total = 0;
    int bad = 0;

    console_rx_port #(.ADDR_WIDTH(22), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_irq_o(rx_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a byte queue plus an overflow flag.
    bit [7:0]    q[$];
    bit          m_ovf = 1'b0;
    logic        exp_rvalid = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                q.delete();
                m_ovf = 1'b0;
                exp_rvalid = 1'b0;
                exp_rdata = 32'h0;
            end else begin
                logic [1:0] idx;
                logic do_pop, do_flush, do_clr, do_set;
                idx = data_addr_i[3:2];
                exp_rvalid = data_req_i;
                do_pop = 1'b0;
                if (data_req_i) begin
                    exp_rdata = 32'h0;
                    if (!data_we_i && idx == 2'd0 && q.size() != 0) begin
                        exp_rdata = 32'h100 | 32'(q[0]);
                        do_pop = 1'b1;
                    end else if (!data_we_i && idx == 2'd1) begin
                        exp_rdata = (q.size() << 8) | (m_ovf ? 4 : 0)
                                  | (q.size() == DEPTH ? 2 : 0) | (q.size() != 0 ? 1 : 0);
                    end
                end
                do_flush = data_req_i && data_we_i && idx == 2'd2 && data_be_i[0] && data_wdata_i[0];
                do_clr   = data_req_i && data_we_i && idx == 2'd2 && data_be_i[0] && data_wdata_i[1];
                do_set   = 1'b0;
                if (do_pop) void'(q.pop_front());
                if (do_flush) q.delete();
                else if (rx_valid_i) begin
                    if (q.size() < DEPTH) q.push_back(rx_data_i);
                    else do_set = 1'b1;
                end
                if (do_clr) m_ovf = 1'b0;
                if (do_set) m_ovf = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                chk("gnt", {31'b0, data_gnt_o}, {31'b0, data_req_i});
                chk("rvalid", {31'b0, data_rvalid_o}, {31'b0, exp_rvalid});
                chk("rdata", data_rdata_o, exp_rdata);
                chk("irq", {31'b0, rx_irq_o}, {31'b0, q.size() != 0});
            end
        end
    end

    // Bus helpers start and end 1 time unit after a rising edge.
    task automatic bus(input logic we, input logic [1:0] idx, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = {18'h0, idx, 2'b00};
        data_be_i    = be;
        data_wdata_i = wd;
        @(posedge clk_i);
        #1;
        data_req_i = 1'b0;
        data_we_i  = 1'b0;
        rd = data_rdata_o;
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        #1;
        chk("reset_rvalid", {31'b0, data_rvalid_o}, 32'h0);
        chk("reset_rdata", data_rdata_o, 32'h0);
        chk("reset_irq", {31'b0, rx_irq_o}, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // 1: empty reads
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t1_status", r, 32'h0);
        bus(1'b0, 2'd0, 4'h0, 32'h0, r);
        chk("t1_rxdata_empty", r, 32'h0);
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t1_status_again", r, 32'h0);

        // 2: two bytes
        strobe(8'h41);
        strobe(8'h42);
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t2_status", r, 32'h0000_0201);
        bus(1'b0, 2'd0, 4'h0, 32'h0, r);
        chk("t2_pop_a", r, 32'h141);
        bus(1'b0, 2'd0, 4'h0, 32'h0, r);
        chk("t2_pop_b", r, 32'h142);
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t2_status_empty", r, 32'h0);

        // 3: overflow
        for (int i = 0; i < 17; i++) strobe(8'(i));
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t3_status_ovf", r, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            bus(1'b0, 2'd0, 4'h0, 32'h0, r);
            chk("t3_drain", r, 32'h100 + 32'(i));
        end
        bus(1'b1, 2'd2, 4'h1, 32'h2, r);
        chk("t3_wr_rdata", r, 32'h0);
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t3_ovf_cleared", r, 32'h0);

        // 4: full + pop + push in one cycle
        for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i));
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h55;
        bus(1'b0, 2'd0, 4'h0, 32'h0, r);
        rx_valid_i = 1'b0;
        chk("t4_oldest", r, 32'h120);
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t4_status_full", r, 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            bus(1'b0, 2'd0, 4'h0, 32'h0, r);
            if (i == 0) chk("t4_first", r, 32'h121);
            if (i == 15) chk("t4_last", r, 32'h155);
        end

        // 5: flush gated by be[0]
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        bus(1'b1, 2'd2, 4'h0, 32'h1, r);
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t5_no_flush", r, 32'h0000_0301);
        chk("t5_irq_high", {31'b0, rx_irq_o}, 32'h1);
        bus(1'b1, 2'd2, 4'h1, 32'h1, r);
        chk("t5_irq_fell", {31'b0, rx_irq_o}, 32'h0);
        bus(1'b0, 2'd1, 4'h0, 32'h0, r);
        chk("t5_flushed", r, 32'h0);

        // 6: reset while a response is outstanding
        strobe(8'h77);
        strobe(8'h78);
        data_req_i  = 1'b1;
        data_addr_i = 22'h4;
        @(posedge clk_i);
        #1;
        data_req_i = 1'b0;
        chk("t6_rvalid_pending", {31'b0, data_rvalid_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        chk("t6_rvalid_dropped", {31'b0, data_rvalid_o}, 32'h0);
        chk("t6_irq_cleared", {31'b0, rx_irq_o}, 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        bus(1'b0, 2'd0, 4'h0, 32'h0, r);
        chk("t6_first_read", r, 32'h0);
        bus(1'b0, 2'd3, 4'h0, 32'h0, r);
        chk("t6_rsvd", r, 32'h0);

        repeat (2) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
